rhd_stream_packetizer: RTL

Downstream consumer of the RHD acquisition controller's M_AXIS sample stream. It buffers 32-bit sample words in a FIFO and emits framed packets: a magic header word, a sequence number, exactly `packet_len` payload words, and TLAST on the final word. The output feeds the DMA/host link. The RHD producer cannot be stalled, so input overflow drops words and is counted rather than back-pressured.

---
 rtl/rhd_pkt_pkg.sv | 20 ++
 rtl/rhd_pkt_fifo.sv | 64 ++++++
 rtl/rhd_stream_packetizer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rhd_pkt_pkg.sv
// Shared types and constants for the RHD stream packetizer.
package rhd_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_PAY,
    ST_PAD
  } pkt_state_t;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hC691_1999;
  localparam logic [31:0] PAD_WORD      = 32'h0000_0000;

  // A zero length request still produces one payload word.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/rhd_pkt_fifo.sv
// Single-clock payload FIFO: block-RAM array with a registered show-ahead head word.
module rhd_pkt_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW-1:0]     w_rd_addr;

  // The head register always tracks the word the read pointer will point at next.
  assign w_rd_addr = i_rd_en ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  always_ff @(posedge aclk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
    if (i_wr_en && (r_wr_ptr == w_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (i_wr_en && !i_rd_en) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!i_wr_en && i_rd_en) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/rhd_stream_packetizer.sv
// Frames the RHD sample stream into MAGIC / sequence / payload packets with TLAST.
module rhd_stream_packetizer
  import rhd_pkt_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 512,
  parameter logic [DATA_W-1:0] MAGIC      = DATA_W'(MAGIC_DEFAULT)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [7:0]        packet_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       drop_count,
  output logic              overflow,
  output logic [31:0]       seq_num
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pkt_state_t        r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_need;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [31:0]       r_seq;
  logic [15:0]       r_drop;
  logic              r_ovf;
  logic              r_en_d;

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_hs;
  logic              w_slot;
  logic              w_en_rise;
  logic [7:0]        w_len_in;
  logic              w_start;
  logic              w_load_pay;
  logic [7:0]        w_n;
  logic              w_pop;
  logic              w_drop;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_valid;
  logic              w_ld_last;
  logic [7:0]        w_ld_need;
  pkt_state_t        w_ld_state;

  assign w_hs       = r_tvalid & m_axis_tready;
  assign w_slot     = ~r_tvalid | m_axis_tready;
  assign w_en_rise  = enable & ~r_en_d;
  assign w_len_in   = eff_len(packet_len);
  assign w_start    = enable ? (w_count >= CW'(w_len_in)) : ~w_empty;
  // r_need counts payload words not yet placed in the output register.
  assign w_load_pay = ((r_state == ST_SEQ) && w_hs) ||
                      ((r_state == ST_PAY) && w_slot && (r_need != 8'd0));
  assign w_n        = (r_state == ST_SEQ) ? r_len : r_need;
  assign w_pop      = w_load_pay & ~w_empty;
  assign w_drop     = s_axis_tvalid & w_full & ~w_pop;
  assign w_wr_en    = s_axis_tvalid & ~w_drop;

  rhd_pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (s_axis_tdata),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_ld_data  = w_head;
    w_ld_valid = 1'b1;
    w_ld_last  = (w_n == 8'd1);
    w_ld_need  = w_n - 8'd1;
    w_ld_state = ST_PAY;
    if (w_empty) begin
      if (!enable) begin
        w_ld_data  = DATA_W'(PAD_WORD);
        w_ld_state = ST_PAD;
      end else begin
        w_ld_valid = 1'b0;
        w_ld_last  = 1'b0;
        w_ld_need  = w_n;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_len    <= 8'd1;
      r_need   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_tdata  <= MAGIC;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_len    <= w_len_in;
            r_state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_hs) begin
            r_tdata <= DATA_W'(r_seq);
            r_state <= ST_SEQ;
          end
        end
        ST_SEQ, ST_PAY: begin
          if (w_load_pay) begin
            r_tdata  <= w_ld_data;
            r_tvalid <= w_ld_valid;
            r_tlast  <= w_ld_last;
            r_need   <= w_ld_need;
            r_state  <= w_ld_state;
          end else if ((r_state == ST_PAY) && w_slot) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_PAD: begin
          if (w_slot) begin
            if (r_need == 8'd0) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_tdata <= DATA_W'(PAD_WORD);
              r_tlast <= (r_need == 8'd1);
              r_need  <= r_need - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Enable rising edge restarts numbering and drop statistics for a new run.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_en_d <= 1'b0;
      r_seq  <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (w_en_rise) begin
        r_seq  <= '0;
        r_drop <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_hs && r_tlast) begin
          r_seq <= r_seq + 32'd1;
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
          end
        end
      end
    end
  end

  assign s_axis_tready = ~areset;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign drop_count    = r_drop;
  assign overflow      = r_ovf;
  assign seq_num       = r_seq;

endmodule
